clip_memory_sequencer: RTL

Sequences record and playback accesses to the two clip memories, one memory access per audio sample. Started by the top-level controller with a mode and a clip number; paced by one-cycle sample strobes from the deserializer (record) or serializer (play). Generates the memory enables, read/write select and address, and keeps the recorded length of each clip so that playback stops at the end of recorded data.

---
 rtl/clip_memory_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clip_memory_sequencer.sv
// Record/playback address sequencer for the two clip memories: one memory access per
// sample strobe, with a recorded length kept per clip so playback stops at the end of data.
module clip_memory_sequencer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic                  clip_i,
    input  logic                  stop_i,
    input  logic                  sample_strobe_i,
    output logic                  memory_0_enable_o,
    output logic                  memory_1_enable_o,
    output logic                  memory_rw_o,
    output logic [ADDR_WIDTH-1:0] memory_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   length_0_o,
    output logic [ADDR_WIDTH:0]   length_1_o
);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                  state_reg, state_next;
    logic                    clip_reg, clip_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic [ADDR_WIDTH:0]     count_inc;
    logic [ADDR_WIDTH:0]     length_reg [2];
    logic [ADDR_WIDTH:0]     length_next [2];
    logic                    length_load;
    logic [ADDR_WIDTH:0]     length_value;
    logic                    access;
    logic [1:0]              enable_reg, enable_next;
    logic                    rw_reg, rw_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    assign count_inc = count_reg + 1'b1;

    always_comb begin
        state_next   = state_reg;
        clip_next    = clip_reg;
        count_next   = count_reg;
        length_load  = 1'b0;
        length_value = count_reg;
        access       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    clip_next  = clip_i;
                    count_next = '0;
                    if (mode_i)
                        state_next = RECORD;
                    else if (length_reg[clip_i] == '0)
                        state_next = FINISH;
                    else
                        state_next = PLAY;
                end
            end
            RECORD: begin
                // The length is committed on the same edge that enters FINISH
                if (sample_strobe_i) begin
                    access     = 1'b1;
                    count_next = count_inc;
                    if (count_reg == LAST_ADDR || stop_i) begin
                        state_next   = FINISH;
                        length_load  = 1'b1;
                        length_value = count_inc;
                    end
                end else if (stop_i) begin
                    state_next  = FINISH;
                    length_load = 1'b1;
                end
            end
            PLAY: begin
                if (sample_strobe_i) begin
                    access     = 1'b1;
                    count_next = count_inc;
                    if (count_inc == length_reg[clip_reg] || stop_i)
                        state_next = FINISH;
                end else if (stop_i) begin
                    state_next = FINISH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rw_next   = access ? (state_reg == RECORD) : rw_reg;
        addr_next = access ? count_reg[ADDR_WIDTH-1:0] : addr_reg;
        busy_next = (state_next == RECORD) || (state_next == PLAY);
        done_next = (state_next == FINISH);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_clip
        assign enable_next[gi] = access && (clip_reg == 1'(gi));
        assign length_next[gi] = (length_load && clip_reg == 1'(gi)) ? length_value
                                                                     : length_reg[gi];

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i)
                length_reg[gi] <= '0;
            else
                length_reg[gi] <= length_next[gi];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            clip_reg   <= 1'b0;
            count_reg  <= '0;
            enable_reg <= '0;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            clip_reg   <= clip_next;
            count_reg  <= count_next;
            enable_reg <= enable_next;
            rw_reg     <= rw_next;
            addr_reg   <= addr_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign memory_0_enable_o = enable_reg[0];
    assign memory_1_enable_o = enable_reg[1];
    assign memory_rw_o       = rw_reg;
    assign memory_addr_o     = addr_reg;
    assign busy_o            = busy_reg;
    assign done_o            = done_reg;
    assign length_0_o        = length_reg[0];
    assign length_1_o        = length_reg[1];

endmodule
